// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and its storage array.
package mem_pkg;
    localparam int XLEN   = 64;
    localparam int STRB_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;
endpackage

// File: rtl/dmem_sram.sv
// Single-port word array with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_sram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [STRB_W-1:0] be,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // One access per enable: byte-masked write, or a read into the output register.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed response latency.
//
// state | meaning
// IDLE  | ready for a request; captures it on req_valid
// WAIT  | latency countdown; array access fires on the edge leaving WAIT
// RESP  | response presented, held until rsp_ready
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [STRB_W-1:0] req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int IDX_W  = XLEN - 3;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    resp_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              cap_we;
    logic [IDX_W-1:0]  cap_idx;
    logic [XLEN-1:0]   cap_wdata;
    logic [STRB_W-1:0] cap_be;
    logic              rsp_load;

    logic              commit;
    logic              acc_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [XLEN-1:0]   acc_wdata;
    logic [STRB_W-1:0] acc_be;
    logic              acc_err;
    logic [XLEN-1:0]   sram_rdata;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[2:0];

    // With LATENCY == 1 the access happens on the accept edge, so the live
    // request feeds the array; otherwise the captured copy does.
    assign acc_we    = (state == IDLE) ? req_we             : cap_we;
    assign acc_idx   = (state == IDLE) ? req_addr[XLEN-1:3] : cap_idx;
    assign acc_wdata = (state == IDLE) ? req_wdata          : cap_wdata;
    assign acc_be    = (state == IDLE) ? req_be             : cap_be;
    assign acc_err   = (acc_idx >= IDX_W'(DEPTH_WORDS));

    assign commit = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                    ((state == WAIT) && (cnt == CNT_W'(1)));

    // Stores and errors return zero data; loads return the array's read register.
    assign rsp_rdata = rsp_load ? sram_rdata : '0;

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .en    (commit && !acc_err),
        .we    (acc_we),
        .addr  (acc_idx[ADDR_W-1:0]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (sram_rdata)
    );

    // Request/response FSM with latency counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_idx   <= req_addr[XLEN-1:3];
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        cnt       <= CNT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_load  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_load  <= !acc_we && !acc_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 1, 4) checked against a word-array model.
module tb_dmem_responder;

    localparam int N = 3;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        longint      cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [63:0] req_addr  [N];
    logic [63:0] req_wdata [N];
    logic [7:0]  req_be    [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [63:0] rsp_rdata [N];
    logic        rsp_err   [N];
    bit          rnd_rdy   [N];

    exp_t        exp_q [N][$];
    logic [63:0] model [int];
    longint      cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        bit seen;

        dmem_responder #(
            .DEPTH_WORDS (512),
            .LATENCY     (L)
        ) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );

        // Monitor: compare every presented response cycle against the queue head.
        always @(negedge clk) begin
            #2;
            if (!rst[g]) begin
                seen = 1'b0;
            end else if (rsp_valid[g]) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("d%0d_unexpected_rsp", g), 64'(rsp_valid[g]), 64'd0);
                end else begin
                    if (!seen) begin
                        check($sformatf("d%0d_latency", g), cyc, exp_q[g][0].cyc);
                        seen = 1'b1;
                    end
                    check($sformatf("d%0d_rdata", g), rsp_rdata[g], exp_q[g][0].rdata);
                    check($sformatf("d%0d_err", g), 64'(rsp_err[g]), 64'(exp_q[g][0].err));
                    check($sformatf("d%0d_ready_busy", g), 64'(req_ready[g]), 64'd0);
                    if (rsp_ready[g]) begin
                        void'(exp_q[g].pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (rnd_rdy[g]) rsp_ready[g] = 1'($urandom_range(0, 1));
        end
    end

    // Drive one request (starting just after a falling edge); returns after the accept edge.
    task automatic issue(input int i, input logic we, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [7:0] be,
                         input bit track, output longint acc);
        int budget;
        exp_t e;
        longint unsigned idx;
        int key;
        logic [63:0] w;
        budget = 0;
        acc = -1;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        req_be[i]    = be;
        while (!req_ready[i] && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready[i]) begin
            check($sformatf("d%0d_accept_timeout", i), 64'(req_ready[i]), 64'd1);
            req_valid[i] = 1'b0;
            return;
        end
        acc = cyc;
        if (track) begin
            idx     = addr[63:3];
            e.cyc   = acc + lat_of(i);
            e.err   = 1'b0;
            e.rdata = '0;
            if (idx >= 512) begin
                e.err = 1'b1;
            end else begin
                key = i * 1024 + int'(idx);
                w = model.exists(key) ? model[key] : '0;
                if (we) begin
                    for (int b = 0; b < 8; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                    model[key] = w;
                end else begin
                    e.rdata = w;
                end
            end
            exp_q[i].push_back(e);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int budget;
        budget = 0;
        while ((exp_q[i].size() != 0 || !req_ready[i]) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("d%0d_drain", i), 64'(exp_q[i].size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        check($sformatf("d%0d_%s_req_ready", i, tag), 64'(req_ready[i]), 64'd1);
        check($sformatf("d%0d_%s_rsp_valid", i, tag), 64'(rsp_valid[i]), 64'd0);
        check($sformatf("d%0d_%s_rsp_rdata", i, tag), rsp_rdata[i], 64'd0);
        check($sformatf("d%0d_%s_rsp_err", i, tag), 64'(rsp_err[i]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc, prev;
        int budget;
        logic [63:0] a;
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; req_be[i] = '0; rsp_ready[i] = 1'b1; rnd_rdy[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) check_reset_outputs(i, "in_reset");
        for (int i = 0; i < N; i++) rst[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) check_reset_outputs(i, "post_reset");

        // LATENCY=2: full store, load back, partial store, sub-word address.
        issue(0, 1'b1, 64'h0, 64'h0F0E0D0C0B0A0908, 8'hFF, 1, acc);
        issue(0, 1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 1, acc);
        issue(0, 1'b0, 64'h10, 64'h0, 8'h00, 1, acc);
        issue(0, 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1, acc);
        issue(0, 1'b0, 64'h10, 64'h0, 8'hFF, 1, acc);
        issue(0, 1'b0, 64'h13, 64'h0, 8'h00, 1, acc);
        issue(0, 1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1, acc);
        issue(0, 1'b0, 64'h10, 64'h0, 8'h00, 1, acc);
        drain(0);

        // Backpressure on a load response.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 64'h10, 64'h0, 8'hFF, 1, acc);
        budget = 0;
        while (!rsp_valid[0] && budget < 20) begin @(negedge clk); budget++; end
        check("d0_bp_valid_seen", 64'(rsp_valid[0]), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("d0_bp_valid_held", 64'(rsp_valid[0]), 64'd1);
            check("d0_bp_req_ready_low", 64'(req_ready[0]), 64'd0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("d0_bp_idle_ready", 64'(req_ready[0]), 64'd1);
        check("d0_bp_idle_valid", 64'(rsp_valid[0]), 64'd0);

        // Out-of-range stores never alias onto in-range words.
        issue(0, 1'b1, 64'h1000, 64'hDEADBEEFDEADBEEF, 8'hFF, 1, acc);
        issue(0, 1'b1, 64'h1010, 64'hDEADBEEFDEADBEEF, 8'hFF, 1, acc);
        issue(0, 1'b1, 64'h8000000000000000, 64'h5555555555555555, 8'hFF, 1, acc);
        issue(0, 1'b0, 64'h1000, 64'h0, 8'hFF, 1, acc);
        issue(0, 1'b0, 64'h0, 64'h0, 8'hFF, 1, acc);
        issue(0, 1'b0, 64'h10, 64'h0, 8'hFF, 1, acc);
        drain(0);

        // Randomized traffic over 16 prefilled words plus out-of-range addresses.
        for (int w = 0; w < 16; w++)
            issue(0, 1'b1, 64'(w * 8), {$urandom(), $urandom()}, 8'hFF, 1, acc);
        rnd_rdy[0] = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 5) == 0) a = {$urandom(), $urandom()} | 64'h1000;
            else a = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            issue(0, 1'($urandom_range(0, 1)), a, {$urandom(), $urandom()},
                  8'($urandom_range(0, 255)), 1, acc);
        end
        rnd_rdy[0] = 1'b0;
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        drain(0);

        // LATENCY=1: back-to-back requests accepted every second cycle.
        issue(1, 1'b1, 64'h40, 64'h0123456789ABCDEF, 8'hFF, 1, prev);
        for (int n = 0; n < 6; n++) begin
            issue(1, 1'(n % 2), 64'h40, 64'(n) << 8, 8'h02, 1, acc);
            check("d1_accept_spacing", 64'(acc - prev), 64'd2);
            prev = acc;
        end
        drain(1);

        // LATENCY=4: reset during WAIT drops the store; reset during RESP keeps it.
        issue(2, 1'b1, 64'h20, 64'hCAFEF00D12345678, 8'hFF, 1, acc);
        issue(2, 1'b1, 64'h28, 64'h0000000011111111, 8'hFF, 1, acc);
        drain(2);
        issue(2, 1'b1, 64'h20, 64'h9999999999999999, 8'hFF, 0, acc);
        rst[2] = 1'b0;
        #1;
        check_reset_outputs(2, "abort_wait");
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        check_reset_outputs(2, "abort_wait_rel");
        issue(2, 1'b0, 64'h20, 64'h0, 8'hFF, 1, acc);
        drain(2);

        rsp_ready[2] = 1'b0;
        issue(2, 1'b1, 64'h28, 64'h7777777777777777, 8'hF0, 1, acc);
        budget = 0;
        while (!rsp_valid[2] && budget < 20) begin @(negedge clk); budget++; end
        check("d2_resp_before_abort", 64'(rsp_valid[2]), 64'd1);
        rst[2] = 1'b0;
        #3;
        exp_q[2].delete();
        check_reset_outputs(2, "abort_resp");
        @(negedge clk);
        rst[2] = 1'b1;
        rsp_ready[2] = 1'b1;
        @(negedge clk);
        issue(2, 1'b0, 64'h28, 64'h0, 8'hFF, 1, acc);
        drain(2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the target end of the memory-stage load/store interface driven by the pipelined RV64I core. Accepts one request at a time over a valid/ready handshake and applies byte-strobed 64-bit writes. Returns read data or a write acknowledgement after a fixed, parameterised latency. Replaces the zero-latency data memory so the core's stall logic can be exercised against a realistic responder.

## Interface
- DEPTH_WORDS, 512: number of 64-bit words; power of two, ≥ 2
- LATENCY, 2: cycles from accepted request cycle to first rsp_valid cycle; ≥ 1
- clk  input  1  clock, rising edge
- rst  input  1  reset; one clock, reset is asynchronous and active-low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  64  byte address; bits [2:0] ignored, word index = req_addr[63:3]
- req_wdata  input  64  store data
- req_be  input  8  byte enables; bit i covers wdata[8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts response
- rsp_rdata  output  64  load data; 0 for stores and errors
- rsp_err  output  1  address out of range

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE); rsp_valid = (state == RESP).
- IDLE: on req_valid, capture we, word index, wdata, be, and err = (req_addr[63:3] ≥ DEPTH_WORDS). Load cnt = LATENCY−1. Next state is RESP if LATENCY == 1, else WAIT.
- WAIT: cnt decrements each cycle. When cnt == 1, the edge moves to RESP.
- Access commits on the edge entering RESP:
  - store: write bytes with be[i]=1 only, other bytes keep their value; rsp_rdata = 0.
  - load: rsp_rdata = full stored word; be is ignored.
  - err: no array write, rsp_rdata = 0, rsp_err = 1.
- RESP: rsp_rdata and rsp_err are held stable while rsp_valid && !rsp_ready. Returns to IDLE on rsp_ready.
- Only one transaction is outstanding; no requests are accepted in WAIT or RESP.
- Storage array is not reset (contents undefined). Writes with be = 0 leave the word unchanged and still produce a response.

## Timing
- Reset values: req_ready = 1 (state IDLE), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, cnt = 0.
- Request accepted in cycle t → rsp_valid first high in cycle t+LATENCY.
- A store accepted in cycle t is visible to any load accepted after its response handshake completes.
- Throughput with rsp_ready tied high: one transaction per LATENCY+1 cycles. req_ready is low from t+1 through the response handshake cycle.
- req_valid may drop before acceptance without effect. Inputs are sampled only in the IDLE acceptance cycle.
- Reset mid-operation aborts the transaction:
  - reset asserted before the RESP-entry edge: no write occurs.
  - reset asserted after that edge: the write persists.
  - on deassertion the block is in IDLE, with no response issued for the aborted request.
- Address width: the index compare uses all 61 upper bits. Addresses beyond DEPTH_WORDS never alias.

## Structure
- Shared package mem_pkg: XLEN = 64, STRB_W = 8, typedef enum logic [1:0] resp_state_t {IDLE, WAIT, RESP}.
- One sub-module, dmem_sram:
  - synchronous single-port DEPTH_WORDS×64 array with per-byte write enable and registered read.
  - read and write are issued on the RESP-entry edge.
- The responder top holds the FSM, latency counter, captured request and error check.

## Test plan
- LATENCY=2: store addr 0x10, wdata 0x1122334455667788, be 0xFF, rsp_ready=1. Then load 0x10 → rsp_valid 2 cycles after acceptance, rsp_rdata 0x1122334455667788, rsp_err 0.
- Partial store to 0x10: wdata 0xAAAAAAAAAAAAAAAA, be 0x0F. Then load 0x10 → 0x11223344AAAAAAAA; load at 0x13 returns the same word.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load response → rsp_valid stays 1, rsp_rdata stable, req_ready 0 throughout; IDLE the cycle after rsp_ready=1.
- Out of range, DEPTH_WORDS=512: store at addr 0x1000 → rsp_err 1, rsp_rdata 0; load at 0x0 afterwards is unchanged.
- LATENCY=1 with back-to-back req_valid and rsp_ready=1 → accepts every second cycle; rsp_valid the cycle after each acceptance.
- Reset asserted (rst=0) during WAIT of a store to 0x20 with LATENCY=4 → after release, all outputs at reset values; load 0x20 returns the prior contents.
